// File: rtl/seven_seg_scan_pkg.sv
// rtl/seven_seg_scan_pkg.sv - shared glyphs, FSM states and decode result type for the 7-seg scan decoder
package seven_seg_scan_pkg;

    // Active-low cathode patterns {g,f,e,d,c,b,a}; a 0 bit is a lit segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic [3:0] code;
        logic       blank;
        logic       err;
    } seg_result_t;

endpackage

// File: rtl/seven_seg_pattern_decoder.sv
// rtl/seven_seg_pattern_decoder.sv - combinational glyph-to-BCD decode; SEG_DECODE_HEX_EN adds hex glyphs A-F
module seven_seg_pattern_decoder
    import seven_seg_scan_pkg::*;
(
    input  logic [6:0]  pattern,
    output seg_result_t result
);

    always_comb begin
        result = '0;
        case (pattern)
            SEG_0:     result.code = 4'd0;
            SEG_1:     result.code = 4'd1;
            SEG_2:     result.code = 4'd2;
            SEG_3:     result.code = 4'd3;
            SEG_4:     result.code = 4'd4;
            SEG_5:     result.code = 4'd5;
            SEG_6:     result.code = 4'd6;
            SEG_7:     result.code = 4'd7;
            SEG_8:     result.code = 4'd8;
            SEG_9:     result.code = 4'd9;
            SEG_BLANK: result.blank = 1'b1;
`ifdef SEG_DECODE_HEX_EN
            SEG_HEX_A: result.code = 4'hA;
            SEG_HEX_B: result.code = 4'hB;
            SEG_HEX_C: result.code = 4'hC;
            SEG_HEX_D: result.code = 4'hD;
            SEG_HEX_E: result.code = 4'hE;
            SEG_HEX_F: result.code = 4'hF;
`endif
            default:   result.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// rtl/seven_seg_scan_decoder.sv - samples a scanned 7-seg drive, settles each digit and publishes whole frames; SEG_DECODE_HEX_EN widens the glyph set
module seven_seg_scan_decoder
    import seven_seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    i_sys_clk,
    input  logic                    i_reset,
    input  logic [NUM_DIGITS-1:0]   i_digits,
    input  logic [7:0]              i_segments,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic [NUM_DIGITS-1:0]   o_dp,
    output logic [NUM_DIGITS-1:0]   o_blank,
    output logic [NUM_DIGITS-1:0]   o_digit_err,
    output logic                    o_frame_valid
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [NUM_DIGITS-1:0]   samp_digits;
    logic [NUM_DIGITS-1:0]   prev_digits;
    logic [7:0]              samp_segments;
    logic [7:0]              prev_segments;
    logic [NUM_DIGITS-1:0]   sel;
    logic                    sel_valid;
    logic                    sample_changed;

    scan_state_t             state;
    scan_state_t             state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    capture;

    seg_result_t             dec;
    logic [NUM_DIGITS-1:0]   seen;
    logic                    publish;
    logic [4*NUM_DIGITS-1:0] shadow_bcd;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [NUM_DIGITS-1:0]   shadow_err;

    // Idle-looking reset values keep the first post-reset sample from matching a real select.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            samp_digits   <= '1;
            prev_digits   <= '1;
            samp_segments <= '1;
            prev_segments <= '1;
        end else begin
            samp_digits   <= i_digits;
            prev_digits   <= samp_digits;
            samp_segments <= i_segments;
            prev_segments <= samp_segments;
        end
    end

    assign sel            = ~samp_digits;
    assign sel_valid      = $onehot(sel);
    assign sample_changed = (samp_digits != prev_digits) || (samp_segments != prev_segments);

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_next = SETTLE;
                    cnt_next   = CNT_W'(1);
                end
            end
            SETTLE: begin
                if (!sel_valid) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (sample_changed) begin
                    cnt_next = CNT_W'(1);
                end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    capture    = 1'b1;
                    cnt_next   = CNT_W'(STABLE_CYCLES);
                    state_next = HELD;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HELD: begin
                if (sample_changed) begin
                    state_next = sel_valid ? SETTLE : IDLE;
                    cnt_next   = sel_valid ? CNT_W'(1) : '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    seven_seg_pattern_decoder u_pattern_decoder (
        .pattern (samp_segments[6:0]),
        .result  (dec)
    );

    // The mask is full for exactly one cycle; that cycle publishes and clears it.
    assign publish = &seen;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            seen          <= '0;
            shadow_bcd    <= '0;
            shadow_dp     <= '0;
            shadow_blank  <= '0;
            shadow_err    <= '0;
            o_bcd         <= '0;
            o_dp          <= '0;
            o_blank       <= '0;
            o_digit_err   <= '0;
            o_frame_valid <= 1'b0;
        end else begin
            o_frame_valid <= publish;
            if (publish) begin
                o_bcd       <= shadow_bcd;
                o_dp        <= shadow_dp;
                o_blank     <= shadow_blank;
                o_digit_err <= shadow_err;
            end
            // A capture landing in the publish cycle starts the next frame.
            seen <= (publish ? '0 : seen) | (capture ? sel : '0);
            if (capture) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (sel[k]) begin
                        shadow_bcd[4*k +: 4] <= dec.code;
                        shadow_blank[k]      <= dec.blank;
                        shadow_err[k]        <= dec.err;
                        shadow_dp[k]         <= ~samp_segments[7];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb/tb_seven_seg_scan_decoder.sv - scoreboard bench for seven_seg_scan_decoder
module tb_seven_seg_scan_decoder;

    localparam int ND    = 8;
    localparam int SC    = 16;
    localparam int DWELL = 20;
    localparam logic [7:0] GLYPH [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic            clk = 1'b0;
    logic            rst;
    logic [ND-1:0]   digits;
    logic [7:0]      segs;
    logic [4*ND-1:0] bcd;
    logic [ND-1:0]   dp;
    logic [ND-1:0]   blank;
    logic [ND-1:0]   err;
    logic            fv;

    always #5 clk = ~clk;

    seven_seg_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .i_sys_clk     (clk),
        .i_reset       (rst),
        .i_digits      (digits),
        .i_segments    (segs),
        .o_bcd         (bcd),
        .o_dp          (dp),
        .o_blank       (blank),
        .o_digit_err   (err),
        .o_frame_valid (fv)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [4*ND-1:0] bcd;
        logic [ND-1:0]   dp;
        logic [ND-1:0]   blank;
        logic [ND-1:0]   err;
    } frame_t;

    frame_t          exp_q[$];
    frame_t          got;
    int              strobe_cnt = 0;
    logic            prev_fv = 1'b0;

    logic [4*ND-1:0] m_bcd   = '0;
    logic [ND-1:0]   m_dp    = '0;
    logic [ND-1:0]   m_blank = '0;
    logic [ND-1:0]   m_err   = '0;
    logic [ND-1:0]   m_seen  = '0;

    // Returns {code, blank, err}.
    function automatic logic [5:0] model_decode(input logic [7:0] s);
        logic [7:0] b;
        b = s | 8'h80;
        case (b)
            8'hC0: return {4'd0, 2'b00};
            8'hF9: return {4'd1, 2'b00};
            8'hA4: return {4'd2, 2'b00};
            8'hB0: return {4'd3, 2'b00};
            8'h99: return {4'd4, 2'b00};
            8'h92: return {4'd5, 2'b00};
            8'h82: return {4'd6, 2'b00};
            8'hF8: return {4'd7, 2'b00};
            8'h80: return {4'd8, 2'b00};
            8'h90: return {4'd9, 2'b00};
            8'hFF: return {4'd0, 2'b10};
`ifdef SEG_DECODE_HEX_EN
            8'h88: return {4'hA, 2'b00};
            8'h83: return {4'hB, 2'b00};
            8'hC6: return {4'hC, 2'b00};
            8'hA1: return {4'hD, 2'b00};
            8'h86: return {4'hE, 2'b00};
            8'h8E: return {4'hF, 2'b00};
`endif
            default: return {4'd0, 2'b01};
        endcase
    endfunction

    task automatic drive_digit(input int idx, input logic [7:0] s, input int cycles);
        logic [5:0] r;
        digits = ~(8'h01 << idx);
        segs   = s;
        if (cycles >= SC) begin
            r                  = model_decode(s);
            m_bcd[4*idx +: 4]  = r[5:2];
            m_blank[idx]       = r[1];
            m_err[idx]         = r[0];
            m_dp[idx]          = ~s[7];
            m_seen[idx]        = 1'b1;
            if (&m_seen) begin
                exp_q.push_back('{m_bcd, m_dp, m_blank, m_err});
                m_seen = '0;
            end
        end
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic drive_invalid(input logic [7:0] d, input int cycles);
        digits = d;
        segs   = 8'($urandom);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain", 64'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (fv === 1'b1) begin
            strobe_cnt++;
            check("strobe_width", prev_fv, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                got = exp_q.pop_front();
                check("frame_bcd", bcd, got.bcd);
                check("frame_dp", dp, got.dp);
                check("frame_blank", blank, got.blank);
                check("frame_err", err, got.err);
            end
        end
        prev_fv = (fv === 1'b1);
    end

    initial begin
        int base;
        rst    = 1'b1;
        digits = '1;
        segs   = '1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            digits = 8'($urandom);
            segs   = 8'($urandom);
            @(negedge clk);
            check("rst_bcd", bcd, 0);
            check("rst_dp", dp, 0);
            check("rst_blank", blank, 0);
            check("rst_err", err, 0);
            check("rst_fv", fv, 0);
            @(posedge clk);
        end
        #1;
        rst    = 1'b0;
        digits = '1;
        segs   = '1;
        repeat (3) @(posedge clk);
        #1;

        // One cycle short of the dwell must not capture; a full dwell captures slot 0 silently.
        drive_digit(0, 8'hA4, SC - 1);
        drive_invalid(8'hFF, 4);
        check("glitch_no_strobe", 64'(strobe_cnt), 0);
        drive_digit(0, 8'hA4, DWELL);
        drive_invalid(8'hFF, 4);
        check("held_no_strobe", 64'(strobe_cnt), 0);
        for (int d = 1; d < ND; d++) drive_digit(d, GLYPH[(d + 4) % 10], DWELL);
        wait_drain();
        check("glitch_slot0", bcd[3:0], 4'd2);

        for (int d = 0; d < ND; d++) drive_digit(d, GLYPH[d + 1], DWELL);
        wait_drain();
        check("full_bcd", bcd, 32'h87654321);

        for (int d = 0; d < ND; d++) begin
            drive_invalid((d % 2 == 1) ? 8'hFC : 8'hFF, 3);
            drive_digit(d, (d == 3) ? 8'hFF : (d == 5) ? 8'h7F : GLYPH[d], DWELL);
        end
        wait_drain();
        check("blank3", blank[3], 1);
        check("blank5", blank[5], 1);
        check("dp5", dp[5], 1);
        check("dp3", dp[3], 0);

        for (int d = 0; d < ND; d++)
            drive_digit(d, (d == 2) ? 8'h88 : (d == 6) ? 8'hFE : GLYPH[9 - d], DWELL);
        wait_drain();
`ifdef SEG_DECODE_HEX_EN
        check("hex_code2", bcd[11:8], 4'hA);
        check("hex_err2", err[2], 0);
`else
        check("nohex_code2", bcd[11:8], 4'h0);
        check("nohex_err2", err[2], 1);
`endif
        check("garbage_err6", err[6], 1);

        for (int d = 0; d < 4; d++) drive_digit(d, GLYPH[d], DWELL);
        digits = '1;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_seen = '0;
        check("midrst_bcd", bcd, 0);
        check("midrst_fv", fv, 0);
        base = strobe_cnt;
        for (int d = 4; d < ND; d++) drive_digit(d, GLYPH[d], DWELL);
        check("midrst_no_early", 64'(strobe_cnt), 64'(base));
        for (int d = 0; d < 4; d++) drive_digit(d, GLYPH[7 - d], DWELL);
        wait_drain();
        check("midrst_one_strobe", 64'(strobe_cnt), 64'(base + 1));
        check("total_strobes", 64'(strobe_cnt), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
